pairwise_mult_pipe: RTL

- Parametrised successor to the team's 4x4 pairwise pipelined multiplier.
- Unsigned WIDTH x WIDTH multiplier built from the even/odd bit split: A = AE + AO, B = BE + BO; product = AE*BE + AE*BO + AO*BE + AO*BO.
- Three-stage pipeline on a single clock, with valid/ready handshakes on input and output, full-pipeline stall under backpressure, a sideband tag carried alongside each product, and an occupancy count.
- Sits between the operand source and the accumulator/datapath consumer.

---
 rtl/pairwise_mult_pipe.sv | 96 +++++++++
 1 files changed

// File: rtl/pairwise_mult_pipe.sv
// Unsigned WIDTH x WIDTH multiplier built from even/odd bit-split partial products.
// Three-stage pipeline with a global advance, valid/ready handshakes and a tag sideband.

module pairwise_pp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] pp
);
    assign pp = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
endmodule

module pairwise_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         occupancy
);
    localparam int PW     = 2 * WIDTH;
    localparam int STAGES = 3;

    logic [WIDTH-1:0] even_mask;
    logic [WIDTH-1:0] ae, ao, be, bo;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mask
        assign even_mask[i] = (i % 2 == 0);
    end

    assign ae = a & even_mask;
    assign ao = a & ~even_mask;
    assign be = b & even_mask;
    assign bo = b & ~even_mask;

    // Partial-product lanes: 0 = ee, 1 = eo, 2 = oe, 3 = oo.
    logic [3:0][WIDTH-1:0] opx, opy;
    logic [3:0][PW-1:0]    pp_d, pp_q;

    assign opx = {ao, ao, ae, ae};
    assign opy = {bo, be, bo, be};

    for (genvar g = 0; g < 4; g++) begin : g_pp
        pairwise_pp #(.WIDTH(WIDTH)) u_pp (
            .x  (opx[g]),
            .y  (opy[g]),
            .pp (pp_d[g])
        );
    end

    logic [STAGES:1] vld_pipe;
    logic [PW-1:0]   s_e, s_o, p_q;
    logic [TAG_W-1:0] t1, t2, t3;
    logic            adv;

    // Whole pipe moves together; a stalled output freezes bubbles too.
    assign adv = !vld_pipe[STAGES] | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            pp_q     <= '0;
            s_e      <= '0;
            s_o      <= '0;
            p_q      <= '0;
            t1       <= '0;
            t2       <= '0;
            t3       <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            pp_q     <= pp_d;
            t1       <= in_tag;
            s_e      <= pp_q[0] + pp_q[1];
            s_o      <= pp_q[2] + pp_q[3];
            t2       <= t1;
            p_q      <= s_e + s_o;
            t3       <= t2;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];
    assign p         = p_q;
    assign out_tag   = t3;
    assign occupancy = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]} + {1'b0, vld_pipe[3]};
endmodule
